// File: rtl/fir_codec_pkg.sv
// Shared definitions for the FIR filter, the I2S transmit serializer and the
// codec receiver: sample format and channel numbering.
package fir_codec_pkg;

    // Audio sample width, s.23 two's complement.
    localparam int SAMPLE_W = 24;

    // Channel indices used on every two-bit per-channel strobe.
    localparam int CH_LEFT  = 0;
    localparam int CH_RIGHT = 1;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage : fir_codec_pkg

// File: rtl/i2s_clk_gen.sv
// I2S master clock generator: divides clk down to BCLK, counts bit slots of a
// stereo frame, drives LRCLK, and tells the data path where the next bit sits.
// All timing strobes refer to the tick cycle, the clk cycle just before a BCLK
// falling edge, so that registered data changes together with that edge.
module i2s_clk_gen #(
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4,
    parameter int POS_W    = $clog2(SLOT_W)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick_o,
    output logic             slot_start_o,
    output logic             slot_ch_o,
    output logic [POS_W-1:0] slot_pos_o,
    output logic             bclk_o,
    output logic             lrclk_o,
    output logic             frame_start_o
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(2 * SLOT_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_W);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BIT_W-1:0] next_pos;
    logic             next_ch;
    logic             tick;
    logic             bclk_q;
    logic             lrclk_q;
    logic             frame_start_q;

    // Next-state for the divider and the bit counter, plus the slot position
    // the bit counter is about to enter.
    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
        bit_cnt_d = bit_cnt_q;
        if (tick) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        end
        next_ch  = (bit_cnt_d >= SLOT_LEN);
        next_pos = next_ch ? (bit_cnt_d - SLOT_LEN) : bit_cnt_d;
    end

    // Counters and the registered BCLK/LRCLK/frame_start outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            bclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            bclk_q        <= (div_cnt_d >= DIV_HALF);
            frame_start_q <= tick && (bit_cnt_d == '0);
            if (tick) begin
                lrclk_q <= next_ch;
            end
        end
    end

    assign tick_o        = tick;
    assign slot_start_o  = tick && (next_pos == '0);
    assign slot_ch_o     = next_ch;
    assign slot_pos_o    = next_pos[POS_W-1:0];
    assign bclk_o        = bclk_q;
    assign lrclk_o       = lrclk_q;
    assign frame_start_o = frame_start_q;

endmodule : i2s_clk_gen

// File: rtl/i2s_tx_serializer.sv
// I2S (Philips) master transmitter fed by the FIR filter. Each channel keeps
// one staged sample and a fresh flag; at every slot start the staged sample of
// that channel is loaded into the shift register and sent MSB first, one BCLK
// after the LRCLK edge. Frame rate comes from the clock generator only, so a
// missing sample resends the previous one (underrun) and an unsent sample that
// gets overwritten is reported as overrun.
module i2s_tx_serializer
    import fir_codec_pkg::*;
#(
    parameter int DATA_W   = SAMPLE_W,
    parameter int SLOT_W   = 32,
    parameter int BCLK_DIV = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               din_valid,
    input  logic signed [DATA_W-1:0] din,
    output logic                     bclk_o,
    output logic                     lrclk_o,
    output logic                     sdata_o,
    output logic                     frame_start,
    output logic                     overrun,
    output logic                     underrun
);

    localparam int POS_W = $clog2(SLOT_W);

    logic                     tick;
    logic                     slot_start;
    logic                     slot_ch;
    logic [POS_W-1:0]         slot_pos;

    logic signed [DATA_W-1:0] staged_q [2];
    logic [1:0]               fresh_q, fresh_d;
    logic signed [DATA_W-1:0] shreg_q, shreg_d;
    logic                     sdata_q, sdata_d;
    logic                     overrun_q, overrun_d;
    logic                     underrun_q, underrun_d;
    logic [1:0]               load_vec;

    // True for slot positions that carry a sample bit (1..DATA_W); position 0
    // is the one-bit I2S delay and positions past DATA_W are padding.
    function automatic logic is_data_bit(input logic [POS_W-1:0] pos);
        return (pos != '0) && (int'(pos) <= DATA_W);
    endfunction

    i2s_clk_gen #(
        .SLOT_W   (SLOT_W),
        .BCLK_DIV (BCLK_DIV),
        .POS_W    (POS_W)
    ) u_clk_gen (
        .clk           (clk),
        .rst           (rst),
        .tick_o        (tick),
        .slot_start_o  (slot_start),
        .slot_ch_o     (slot_ch),
        .slot_pos_o    (slot_pos),
        .bclk_o        (bclk_o),
        .lrclk_o       (lrclk_o),
        .frame_start_o (frame_start)
    );

    // Fresh flags, error pulses and the shift/serial data path. A write that
    // coincides with the load of its own channel is not an overrun: the load
    // takes the old sample and the new one stays fresh for the next frame.
    always_comb begin
        load_vec[CH_LEFT]  = slot_start && (slot_ch == 1'b0);
        load_vec[CH_RIGHT] = slot_start && (slot_ch == 1'b1);

        overrun_d  = |(din_valid & fresh_q & ~load_vec);
        underrun_d = slot_start && !fresh_q[slot_ch];
        fresh_d    = (fresh_q & ~load_vec) | din_valid;

        shreg_d = shreg_q;
        sdata_d = sdata_q;
        if (tick) begin
            if (slot_start) begin
                shreg_d = staged_q[slot_ch];
                sdata_d = 1'b0;
            end else if (is_data_bit(slot_pos)) begin
                sdata_d = shreg_q[DATA_W-1];
                shreg_d = shreg_q << 1;
            end else begin
                sdata_d = 1'b0;
            end
        end
    end

    // Staging registers: written from the filter on any cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            staged_q[CH_LEFT]  <= '0;
            staged_q[CH_RIGHT] <= '0;
        end else begin
            if (din_valid[CH_LEFT]) begin
                staged_q[CH_LEFT] <= din;
            end
            if (din_valid[CH_RIGHT]) begin
                staged_q[CH_RIGHT] <= din;
            end
        end
    end

    // Fresh flags, shift register, serial data and the error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            fresh_q    <= '0;
            shreg_q    <= '0;
            sdata_q    <= 1'b0;
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            fresh_q    <= fresh_d;
            shreg_q    <= shreg_d;
            sdata_q    <= sdata_d;
            overrun_q  <= overrun_d;
            underrun_q <= underrun_d;
        end
    end

    assign sdata_o  = sdata_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

endmodule : i2s_tx_serializer

// File: tb/tb_i2s_tx_serializer.sv
// Bench for the I2S transmit serializer: a time-indexed behavioural model of
// the frame plus directed scenarios and randomized sample traffic.
module tb_i2s_tx_serializer;

    localparam int W  = 24;
    localparam int S  = 32;
    localparam int D  = 4;
    localparam int FR = 2 * S * D;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [1:0]          din_valid = 2'b00;
    logic signed [W-1:0] din = '0;
    logic                bclk_o, lrclk_o, sdata_o, frame_start, overrun, underrun;

    always #5 clk = ~clk;

    i2s_tx_serializer #(
        .DATA_W   (W),
        .SLOT_W   (S),
        .BCLK_DIV (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din         (din),
        .bclk_o      (bclk_o),
        .lrclk_o     (lrclk_o),
        .sdata_o     (sdata_o),
        .frame_start (frame_start),
        .overrun     (overrun),
        .underrun    (underrun)
    );

    int checks   = 0;
    int failures = 0;

    // Model: k = clk cycles since the last reset edge; staged/fresh per channel;
    // m_cur = sample of the slot currently on the wire.
    int          k = 0;
    logic [W-1:0] m_staged [2];
    logic [1:0]  m_fresh = 2'b00;
    logic [W-1:0] m_cur = '0;
    logic        m_ov = 1'b0, m_ur = 1'b0;
    bit          model_live = 0;

    initial begin
        m_staged[0] = '0;
        m_staged[1] = '0;
        forever begin : mdl
            logic tick, load;
            int   nb, ch;
            @(posedge clk);
            if (rst) begin
                k = 0; m_staged[0] = '0; m_staged[1] = '0;
                m_fresh = 2'b00; m_cur = '0; m_ov = 1'b0; m_ur = 1'b0;
            end else begin
                tick = ((k % D) == D - 1);
                nb   = ((k + 1) / D) % (2 * S);
                load = tick && ((nb % S) == 0);
                ch   = (nb >= S) ? 1 : 0;
                m_ov = 1'b0;
                m_ur = 1'b0;
                for (int c = 0; c < 2; c++)
                    if (din_valid[c] && m_fresh[c] && !(load && ch == c)) m_ov = 1'b1;
                if (load) begin
                    m_cur       = m_staged[ch];
                    m_ur        = !m_fresh[ch];
                    m_fresh[ch] = 1'b0;
                end
                for (int c = 0; c < 2; c++)
                    if (din_valid[c]) begin
                        m_staged[c] = din;
                        m_fresh[c]  = 1'b1;
                    end
                k++;
            end
            model_live = 1;
        end
    end

    function automatic logic [5:0] expect_vec();
        int   p, b;
        logic e_bclk, e_lr, e_sd, e_fs;
        p      = (k / D) % S;
        b      = (k / D) % (2 * S);
        e_bclk = (k % D) >= D / 2;
        e_lr   = b >= S;
        e_sd   = (p >= 1 && p <= W) ? m_cur[W-p] : 1'b0;
        e_fs   = ((k % FR) == 0) && (k != 0);
        return {e_bclk, e_lr, e_sd, e_fs, m_ov, m_ur};
    endfunction

    // Per-cycle compare plus observation counters taken from DUT outputs only.
    int   cyc = 0, n_ur = 0, n_ov = 0;
    int   last_fs = -1, fs_period = 0, last_lr = -1, lr_period = 0;
    logic prev_lr = 1'b0;

    initial forever begin
        logic [5:0] got, exp_v;
        @(negedge clk);
        cyc++;
        if (model_live) begin
            got   = {bclk_o, lrclk_o, sdata_o, frame_start, overrun, underrun};
            exp_v = expect_vec();
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL cycle_match cyc=%0d k=%0d {bclk,lr,sd,fs,ov,ur} got=%b exp=%b",
                         cyc, k, got, exp_v);
            end
            n_ur += int'(underrun);
            n_ov += int'(overrun);
            if (frame_start) begin
                if (last_fs >= 0) fs_period = cyc - last_fs;
                last_fs = cyc;
            end
            if (lrclk_o != prev_lr) begin
                if (last_lr >= 0) lr_period = cyc - last_lr;
                last_lr = cyc;
            end
            prev_lr = lrclk_o;
            if (rst) begin
                last_fs = -1;
                last_lr = -1;
            end
        end
    end

    // Serial word capture: rebuild each slot's sample from BCLK rising edges.
    int           mpos = -1;
    logic         mprev_lr = 1'b0, mprev_b = 1'b0;
    logic [W-1:0] mword = '0;
    logic [W-1:0] last_word [2];

    initial begin
        last_word[0] = '0;
        last_word[1] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                mpos = -1; mprev_lr = 1'b0; mprev_b = 1'b0;
            end else begin
                if (bclk_o && !mprev_b) begin
                    if (lrclk_o != mprev_lr) mpos = 0;
                    else mpos++;
                    mprev_lr = lrclk_o;
                    if (mpos >= 1 && mpos <= W) begin
                        mword = {mword[W-2:0], sdata_o};
                        if (mpos == W) last_word[lrclk_o] = mword;
                    end
                end
                mprev_b = bclk_o;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp_v);
        end
    endtask

    task automatic wait_phase(input int v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((k % FR) != v) && n < 2000);
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL wait_phase_%0d timeout k=%0d", v, k);
        end
    endtask

    task automatic stage(input logic [1:0] mask, input logic [W-1:0] data);
        din_valid = mask;
        din       = data;
        @(negedge clk);
        din_valid = 2'b00;
    endtask

    int           ur0, ov0, hi, rises;
    logic         pb;
    logic [W-1:0] rv, va, vb;

    initial begin
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;

        // Reset mid-frame, in a cycle where BCLK and LRCLK would both be high.
        wait_phase(130);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_outputs", {29'd0, bclk_o, lrclk_o, sdata_o}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        last_word[0] = '1;
        last_word[1] = '1;
        ur0 = n_ur;
        wait_phase(240);
        chk("rst_left_zero", last_word[0], 32'd0);
        chk("rst_right_zero", last_word[1], 32'd0);
        wait_phase(10);
        chk("rst_underruns", n_ur - ur0, 32'd2);

        // Extreme-pattern samples staged ahead of the frame.
        wait_phase(200);
        ur0 = n_ur; ov0 = n_ov;
        stage(2'b01, 24'h800001);
        stage(2'b10, 24'h7FFFFE);
        wait_phase(0); wait_phase(240);
        chk("pat_left", last_word[0], 32'h800001);
        chk("pat_right", last_word[1], 32'h7FFFFE);
        chk("pat_no_underrun", n_ur - ur0, 32'd0);
        chk("pat_no_overrun", n_ov - ov0, 32'd0);

        // Left staged twice before its load: newer sample wins, one overrun.
        wait_phase(200);
        ur0 = n_ur; ov0 = n_ov;
        rv = W'($urandom);
        stage(2'b01, 24'h000001);
        stage(2'b10, rv);
        wait_phase(210);
        stage(2'b01, 24'h000002);
        wait_phase(0); wait_phase(240);
        chk("ovr_count", n_ov - ov0, 32'd1);
        chk("ovr_left", last_word[0], 32'h000002);
        chk("ovr_right", last_word[1], 32'(rv));
        chk("ovr_no_underrun", n_ur - ur0, 32'd0);

        // Right not restaged for a frame: underrun and the old value resent.
        wait_phase(200);
        stage(2'b01, W'($urandom));
        stage(2'b10, 24'h123456);
        wait_phase(0); wait_phase(200);
        ur0 = n_ur;
        stage(2'b01, W'($urandom));
        wait_phase(0); wait_phase(240);
        chk("udr_count", n_ur - ur0, 32'd1);
        chk("udr_resend", last_word[1], 32'h123456);

        // Left write in the exact cycle of the left slot load.
        va = 24'h35A5C3;
        vb = 24'hC0FFEE;
        wait_phase(200);
        stage(2'b01, va);
        stage(2'b10, W'($urandom));
        wait_phase(255);
        ur0 = n_ur; ov0 = n_ov;
        stage(2'b01, vb);
        wait_phase(200);
        stage(2'b10, W'($urandom));
        wait_phase(240);
        chk("coll_old_sent", last_word[0], 32'(va));
        wait_phase(0); wait_phase(240);
        chk("coll_new_sent", last_word[0], 32'(vb));
        chk("coll_no_underrun", n_ur - ur0, 32'd0);
        chk("coll_no_overrun", n_ov - ov0, 32'd0);

        // Frame, LRCLK and BCLK timing seen on the pins.
        wait_phase(100);
        chk("fs_period", fs_period, 32'd256);
        chk("lr_half_period", lr_period, 32'd128);
        hi = 0; rises = 0; pb = bclk_o;
        repeat (64) begin
            @(negedge clk);
            hi += int'(bclk_o);
            if (bclk_o && !pb) rises++;
            pb = bclk_o;
        end
        chk("bclk_high_cycles", hi, 32'd32);
        chk("bclk_periods", rises, 32'd16);

        // Random sample traffic, load-cycle collisions and occasional resets.
        repeat (40 * FR) begin
            @(negedge clk);
            if ((k % 128) == 127 && ($urandom % 4) == 0) begin
                din_valid = 2'($urandom_range(1, 3));
                din       = W'($urandom);
            end else if (($urandom % 50) == 0) begin
                din_valid = 2'($urandom_range(1, 3));
                din       = W'($urandom);
            end else begin
                din_valid = 2'b00;
            end
            if (($urandom % 4000) == 0) begin
                din_valid = 2'b00;
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end
        end
        din_valid = 2'b00;
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_i2s_tx_serializer
